// File: rtl/mbi6120_pkg.sv
// Shared types and constants for the MBI6120 single-wire packet transmitter.
package mbi6120_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_HEADER,
        ST_GAP,
        ST_FRAME,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        SYM_0,
        SYM_1,
        SYM_GAP
    } sym_t;

    localparam logic [11:0] PREAMBLE       = 12'hFFF;
    localparam int          FRAME_BITS     = 36;

    localparam logic [7:0]  CMD_GRAYSCALE  = 8'h00;
    localparam logic [7:0]  CMD_SOFT_RESET = 8'h55;

    localparam logic [1:0]  GCLK_0         = 2'b00;
    localparam logic [1:0]  GCLK_1         = 2'b01;
    localparam logic [1:0]  GCLK_2         = 2'b10;
    localparam logic [1:0]  GCLK_3         = 2'b11;

    function automatic logic [FRAME_BITS-1:0] header_word(
        input logic [1:0] gclk,
        input logic [7:0] command,
        input logic [9:0] count_m1
    );
        return {PREAMBLE, 2'b00, gclk, command, 2'b00, count_m1};
    endfunction

endpackage

// File: rtl/mbi6120_symbol_gen.sv
// Pulse-width symbol generator: one '0', '1' or gap symbol per sym_start,
// with sym_done on the final cycle so a following symbol abuts it exactly.
module mbi6120_symbol_gen
    import mbi6120_pkg::*;
#(
    parameter int BIT_CYC = 48,
    parameter int TW_CYC  = 5
) (
    input  logic pixel_clock,
    input  logic rst,
    input  logic sym_start,
    input  sym_t sym_type,
    output logic sym_done,
    output logic data_out
);

    localparam int CW = $clog2(2 * BIT_CYC);

    logic [CW-1:0] r_cnt;
    logic          r_active;
    sym_t          r_type;
    logic [CW-1:0] w_high;
    logic [CW-1:0] w_last;

    always_comb begin
        w_high = CW'(TW_CYC);
        w_last = CW'(BIT_CYC - 1);
        case (r_type)
            SYM_1: begin
                w_high = CW'(BIT_CYC - TW_CYC);
                w_last = CW'(BIT_CYC - 1);
            end
            SYM_GAP: begin
                w_high = CW'(2 * BIT_CYC - TW_CYC);
                w_last = CW'(2 * BIT_CYC - 1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge pixel_clock) begin
        if (rst) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
        end else if (sym_start) begin
            r_active <= 1'b1;
            r_cnt    <= '0;
        end else if (r_active) begin
            if (r_cnt == w_last) r_active <= 1'b0;
            else                 r_cnt    <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge pixel_clock) begin
        if (sym_start) r_type <= sym_type;
    end

    assign sym_done = r_active && (r_cnt == w_last);
    assign data_out = r_active && (r_cnt < w_high);

endmodule

// File: rtl/mbi6120_frame_tx.sv
// MBI6120 cascade packet engine: latch-low, header, one frame per IC, with a
// one-triple prefetch buffer. Optional macro MBI6120_DOUBLE_PIXEL_EN.
module mbi6120_frame_tx
    import mbi6120_pkg::*;
#(
    parameter int BIT_CYC        = 48,
    parameter int TW_CYC         = 5,
    parameter int LATCH_CYC      = 18000,
    parameter int GS_BITS        = 12,
    parameter int CH_PER_IC      = 3,
    parameter int GAPS_PER_FRAME = 2
) (
    input  logic               pixel_clock,
    input  logic               rst,
    input  logic               start,
    input  logic [9:0]         ic_count_m1,
    input  logic [1:0]         gclk_sel,
    input  logic [7:0]         cmd,
`ifdef MBI6120_DOUBLE_PIXEL_EN
    input  logic               double_pixel,
`endif
    input  logic [GS_BITS-1:0] s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output logic               busy,
    output logic               done,
    output logic               underrun,
    output logic               data_out
);

    localparam int LW  = $clog2(LATCH_CYC);
    localparam int BIW = $clog2(FRAME_BITS);
    localparam int GW  = $clog2(GAPS_PER_FRAME + 1);
    localparam int BCW = $clog2(CH_PER_IC + 1);
    localparam int NW  = $clog2(1024 * CH_PER_IC + 1);

    state_t                r_state;
    state_t                w_next;
    logic [LW-1:0]         r_lat_cnt;
    logic [BIW-1:0]        r_bit_idx;
    logic [GW-1:0]         r_gap_idx;
    logic [10:0]           r_ic_left;
    logic [BCW-1:0]        r_buf_cnt;
    logic [NW-1:0]         r_taken;
    logic [NW-1:0]         r_need;
    logic                  r_underrun;
    logic                  r_dp;
    logic                  r_second;
    logic [FRAME_BITS-1:0] r_shift;
    logic [FRAME_BITS-1:0] r_buf;

    logic                  w_dp;
    logic                  w_start_acc;
    logic                  w_sym_start;
    sym_t                  w_sym_type;
    logic                  w_sym_done;
    logic                  w_shift;
    logic                  w_load;
    logic                  w_buf_full;
    logic                  w_take;
    logic [FRAME_BITS-1:0] w_frame;

`ifdef MBI6120_DOUBLE_PIXEL_EN
    assign w_dp = double_pixel;
`else
    assign w_dp = 1'b0;
`endif

    assign w_start_acc = (r_state == ST_IDLE) && start;
    assign w_buf_full  = (r_buf_cnt == BCW'(CH_PER_IC));
    assign w_frame     = w_buf_full ? r_buf : '0;

    always_ff @(posedge pixel_clock) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_sym_start = 1'b0;
        w_sym_type  = SYM_0;
        w_shift     = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_LATCH;
            end
            ST_LATCH: begin
                if (r_lat_cnt == LW'(LATCH_CYC - 1)) begin
                    w_next      = ST_HEADER;
                    w_sym_start = 1'b1;
                    w_sym_type  = r_shift[FRAME_BITS-1] ? SYM_1 : SYM_0;
                end
            end
            ST_HEADER, ST_FRAME: begin
                if (w_sym_done) begin
                    w_sym_start = 1'b1;
                    if (r_bit_idx == BIW'(FRAME_BITS - 1)) begin
                        w_next     = ST_GAP;
                        w_sym_type = SYM_GAP;
                    end else begin
                        w_shift    = 1'b1;
                        w_sym_type = r_shift[FRAME_BITS-2] ? SYM_1 : SYM_0;
                    end
                end
            end
            ST_GAP: begin
                if (w_sym_done) begin
                    if (r_gap_idx != GW'(GAPS_PER_FRAME - 1)) begin
                        w_sym_start = 1'b1;
                        w_sym_type  = SYM_GAP;
                    end else if (r_ic_left != '0) begin
                        w_next      = ST_FRAME;
                        w_load      = 1'b1;
                        w_sym_start = 1'b1;
                        w_sym_type  = w_frame[FRAME_BITS-1] ? SYM_1 : SYM_0;
                    end else begin
                        w_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // The load cycle refuses samples so a partial triple is dropped cleanly.
    assign busy    = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign s_ready = busy && !w_buf_full && (r_taken < r_need) && !w_load;
    assign w_take  = s_valid && s_ready;

    always_ff @(posedge pixel_clock) begin
        if (rst) begin
            r_lat_cnt  <= '0;
            r_bit_idx  <= '0;
            r_gap_idx  <= '0;
            r_ic_left  <= '0;
            r_buf_cnt  <= '0;
            r_taken    <= '0;
            r_need     <= '0;
            r_underrun <= 1'b0;
            r_dp       <= 1'b0;
            r_second   <= 1'b0;
        end else begin
            if (w_start_acc) begin
                r_lat_cnt  <= '0;
                r_buf_cnt  <= '0;
                r_taken    <= '0;
                r_underrun <= 1'b0;
                r_second   <= 1'b0;
                r_dp       <= w_dp;
                r_ic_left  <= {1'b0, ic_count_m1} + 11'd1;
                if (w_dp) r_need <= NW'(((32'(ic_count_m1) + 2) >> 1) * CH_PER_IC);
                else      r_need <= NW'((32'(ic_count_m1) + 1) * CH_PER_IC);
            end else if (r_state == ST_LATCH) begin
                r_lat_cnt <= r_lat_cnt + 1'b1;
            end

            if ((r_state == ST_LATCH && w_next == ST_HEADER) || w_load)
                r_bit_idx <= '0;
            else if (w_shift)
                r_bit_idx <= r_bit_idx + 1'b1;

            if (r_state != ST_GAP && w_next == ST_GAP)
                r_gap_idx <= '0;
            else if (r_state == ST_GAP && w_sym_done)
                r_gap_idx <= r_gap_idx + 1'b1;

            if (w_take) r_taken <= r_taken + 1'b1;

            // In double-pixel mode a full triple survives its first use.
            if (w_load) begin
                r_ic_left <= r_ic_left - 11'd1;
                if (!w_buf_full) r_underrun <= 1'b1;
                if (r_dp && !r_second && w_buf_full) begin
                    r_second <= 1'b1;
                end else begin
                    r_buf_cnt <= '0;
                    r_second  <= 1'b0;
                end
            end else if (w_take) begin
                r_buf_cnt <= r_buf_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge pixel_clock) begin
        if (w_take) r_buf <= {r_buf[FRAME_BITS-GS_BITS-1:0], s_data};
        if (w_start_acc)  r_shift <= header_word(gclk_sel, cmd, ic_count_m1);
        else if (w_load)  r_shift <= w_frame;
        else if (w_shift) r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
    end

    assign done     = (r_state == ST_DONE);
    assign underrun = r_underrun;

    mbi6120_symbol_gen #(
        .BIT_CYC (BIT_CYC),
        .TW_CYC  (TW_CYC)
    ) u_symbol_gen (
        .pixel_clock (pixel_clock),
        .rst         (rst),
        .sym_start   (w_sym_start),
        .sym_type    (w_sym_type),
        .sym_done    (w_sym_done),
        .data_out    (data_out)
    );

endmodule

// File: tb/tb_mbi6120_frame_tx.sv
// Bench for mbi6120_frame_tx: decodes the serial line back into symbols and
// compares packets against a queue-based model of the expected packet.
module tb_mbi6120_frame_tx;
    import mbi6120_pkg::*;

    localparam int BIT_CYC   = 8;
    localparam int TW_CYC    = 2;
    localparam int LATCH_CYC = 64;
    localparam int FRAME_CYC = 40 * BIT_CYC;
    localparam int NSRC      = 4096;

    logic        pixel_clock = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  ic_count_m1;
    logic [1:0]  gclk_sel;
    logic [7:0]  cmd;
    logic [11:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        busy;
    logic        done;
    logic        underrun;
    logic        data_out;
`ifdef MBI6120_DOUBLE_PIXEL_EN
    logic        dp_in;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [11:0] src_mem [NSRC];
    int          src_idx = 0;
    int          src_mode = 0;
    int          sym_q[$];
    int          tim_err = 0;

    always #5 pixel_clock = ~pixel_clock;

    mbi6120_frame_tx #(
        .BIT_CYC        (BIT_CYC),
        .TW_CYC         (TW_CYC),
        .LATCH_CYC      (LATCH_CYC),
        .GS_BITS        (12),
        .CH_PER_IC      (3),
        .GAPS_PER_FRAME (2)
    ) dut (
        .pixel_clock (pixel_clock),
        .rst         (rst),
        .start       (start),
        .ic_count_m1 (ic_count_m1),
        .gclk_sel    (gclk_sel),
        .cmd         (cmd),
`ifdef MBI6120_DOUBLE_PIXEL_EN
        .double_pixel (dp_in),
`endif
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .busy        (busy),
        .done        (done),
        .underrun    (underrun),
        .data_out    (data_out)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sym_period(input int s);
        if (s == 0 || s == 1) return BIT_CYC;
        if (s == 2)           return 2 * BIT_CYC;
        return -1;
    endfunction

    // Source: sample index advances on every handshake seen mid-cycle.
    initial begin
        bit xfer;
        s_valid = 1'b0;
        s_data  = '0;
        forever begin
            @(negedge pixel_clock);
            xfer = s_valid && s_ready;
            @(posedge pixel_clock);
            #1;
            if (xfer) src_idx++;
            case (src_mode)
                0:       s_valid = 1'b0;
                1:       s_valid = 1'b1;
                default: s_valid = 1'($urandom_range(0, 1));
            endcase
            s_data = src_mem[src_idx % NSRC];
        end
    end

    // Line decoder: pulse width gives symbol type, rise-to-rise gives period.
    initial begin
        int   hi = 0;
        int   cyc = 0;
        int   prev_rise = -100000;
        int   prev_sym = -1;
        int   s;
        logic prev_d = 1'b0;
        forever begin
            @(negedge pixel_clock);
            cyc++;
            if (data_out === 1'b1 && prev_d !== 1'b1) begin
                if (prev_sym >= 0 && (cyc - prev_rise) < 4 * BIT_CYC &&
                    (cyc - prev_rise) != sym_period(prev_sym))
                    tim_err++;
                prev_rise = cyc;
                hi = 0;
            end
            if (data_out === 1'b1) begin
                hi++;
            end else if (prev_d === 1'b1) begin
                if (hi == TW_CYC)                    s = 0;
                else if (hi == BIT_CYC - TW_CYC)     s = 1;
                else if (hi == 2 * BIT_CYC - TW_CYC) s = 2;
                else                                 s = 3;
                sym_q.push_back(s);
                prev_sym = s;
            end
            prev_d = data_out;
        end
    end

    task automatic pop_word(output logic [63:0] w);
        int  s;
        bit  bad;
        bad = 1'b0;
        w   = '0;
        for (int b = 0; b < FRAME_BITS; b++) begin
            s = sym_q.pop_front();
            if (s > 1) bad = 1'b1;
            w = {w[62:0], (s == 1)};
        end
        if (bad) w[48] = 1'b1;
    endtask

    task automatic tick();
        @(posedge pixel_clock);
        #1;
    endtask

    task automatic send_start(input int icm1, input logic [1:0] g, input logic [7:0] c, input bit dp);
        ic_count_m1 = 10'(icm1);
        gclk_sel    = g;
        cmd         = c;
`ifdef MBI6120_DOUBLE_PIXEL_EN
        dp_in       = dp;
`else
        if (dp) $display("double-pixel request ignored in this build");
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_packet(input int icm1, input logic [1:0] g, input logic [7:0] c,
                              input int mode, input bit dp, input int poke);
        int          n, base, k, exp_k, need, extra, gap_bad, t, s;
        bit          seen;
        logic [63:0] w, exp_w;
        n        = icm1 + 1;
        src_mode = mode;
        tick();
        sym_q.delete();
        tim_err = 0;
        base    = src_idx;
        send_start(icm1, g, c, dp);
        chk("busy_after_start", busy, 1);
        chk("underrun_cleared", underrun, 0);
        exp_k = LATCH_CYC + (n + 1) * FRAME_CYC;
        k     = 0;
        seen  = 1'b0;
        while (!seen && k < exp_k + 50) begin
            start = (k == poke);
            tick();
            k++;
            if (k == LATCH_CYC / 2) chk("latch_low", data_out, 0);
            seen = (done === 1'b1);
        end
        start = 1'b0;
        chk("done_cycle", k, exp_k);
        chk("busy_at_done", busy, 0);
        chk("underrun_at_done", underrun, (mode == 0));
        extra = 0;
        for (int i = 0; i < LATCH_CYC + 20; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) extra++;
        end
        chk("no_extra_packet", extra, 0);
        need = (mode == 0) ? 0 : (dp ? ((n + 1) / 2) * 3 : n * 3);
        chk("samples_taken", src_idx - base, need);
        chk("symbol_count", sym_q.size(), 38 * (n + 1));
        if (sym_q.size() == 38 * (n + 1)) begin
            gap_bad = 0;
            pop_word(w);
            exp_w = {28'b0, PREAMBLE, 2'b00, g, c, 2'b00, 10'(icm1)};
            chk("header_word", w, exp_w);
            for (int i = 0; i < 2; i++) begin s = sym_q.pop_front(); if (s != 2) gap_bad++; end
            for (int i = 0; i < n; i++) begin
                t = dp ? i / 2 : i;
                if (mode == 0) exp_w = '0;
                else exp_w = {28'b0, src_mem[(base + 3 * t) % NSRC],
                              src_mem[(base + 3 * t + 1) % NSRC],
                              src_mem[(base + 3 * t + 2) % NSRC]};
                pop_word(w);
                chk($sformatf("frame_%0d", i), w, exp_w);
                for (int j = 0; j < 2; j++) begin s = sym_q.pop_front(); if (s != 2) gap_bad++; end
            end
            chk("gap_symbols", gap_bad, 0);
        end
        chk("symbol_timing", tim_err, 0);
    endtask

    task automatic abort_now(input string tag);
        int   k;
        logic prev;
        k    = 0;
        prev = data_out;
        while (k < 4 * BIT_CYC && !(data_out === 1'b1 && prev === 1'b0)) begin
            prev = data_out;
            tick();
            k++;
        end
        chk({tag, "_line_high"}, data_out, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk({tag, "_dout"}, data_out, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ready"}, s_ready, 0);
    endtask

    initial begin
        logic [63:0] w;
        int          base;
        for (int i = 0; i < NSRC; i++) src_mem[i] = 12'($urandom);
        rst = 1'b1; start = 1'b0; ic_count_m1 = '0; gclk_sel = '0; cmd = '0;
`ifdef MBI6120_DOUBLE_PIXEL_EN
        dp_in = 1'b0;
`endif
        repeat (3) tick();
        chk("rst_dout", data_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_ready", s_ready, 0);
        rst = 1'b0;
        tick();

        src_mem[0] = 12'hABC; src_mem[1] = 12'h123; src_mem[2] = 12'hFFF;
        run_packet(0, GCLK_1, CMD_GRAYSCALE, 1, 1'b0, -1);
        run_packet(1, GCLK_0, CMD_GRAYSCALE, 0, 1'b0, -1);
        run_packet(1, GCLK_2, CMD_GRAYSCALE, 2, 1'b0, LATCH_CYC + FRAME_CYC + 50);

        src_mode = 1;
        tick();
        send_start(1, GCLK_3, CMD_GRAYSCALE, 1'b0);
        repeat (LATCH_CYC + FRAME_CYC + 40) tick();
        abort_now("abort_frame");
        run_packet(2, GCLK_3, CMD_SOFT_RESET, 2, 1'b0, -1);

        run_packet(99, GCLK_1, CMD_GRAYSCALE, 1, 1'b0, -1);

        src_mode = 1;
        tick();
        sym_q.delete();
        base = src_idx;
        send_start(1023, GCLK_2, CMD_SOFT_RESET, 1'b0);
        repeat (LATCH_CYC + FRAME_BITS * BIT_CYC + 4) tick();
        chk("maxcnt_prefetch", src_idx - base, 3);
        chk("maxcnt_hdr_syms", (sym_q.size() >= FRAME_BITS), 1);
        if (sym_q.size() >= FRAME_BITS) begin
            pop_word(w);
            chk("maxcnt_header", w, {28'b0, PREAMBLE, 2'b00, GCLK_2, CMD_SOFT_RESET, 2'b00, 10'h3FF});
        end
        abort_now("abort_max");

        for (int r = 0; r < 5; r++)
            run_packet(int'($urandom_range(0, 5)), 2'($urandom),
                       ($urandom_range(0, 1) == 1) ? CMD_SOFT_RESET : CMD_GRAYSCALE,
                       int'($urandom_range(1, 2)), 1'b0, -1);

`ifdef MBI6120_DOUBLE_PIXEL_EN
        run_packet(3, GCLK_1, CMD_GRAYSCALE, 1, 1'b1, -1);
        run_packet(4, GCLK_0, CMD_GRAYSCALE, 2, 1'b1, -1);
        run_packet(2, GCLK_3, CMD_GRAYSCALE, 1, 1'b0, -1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mbi6120_frame_tx.md
Name: mbi6120_frame_tx

Overview:
- Parametrised successor MBI6120 single-wire output engine; streams a complete packet to a cascade of MBI6120 LED drivers.
- Packet sequence: latch-low period, 36-bit header, one 36-bit grayscale frame per IC.
- Header carries an exact IC count supplied by the host, not derived from a word count.
- Grayscale samples arrive on a valid/ready stream from the upstream memory reader; a one-frame prefetch buffer hides the request latency.

Parameters:
BIT_CYC, 48, pixel_clock cycles per bit period Tbit (2 us at 24 MHz)
TW_CYC, 5, short pulse width Tw in cycles; legal range 0.08..0.25 * BIT_CYC
LATCH_CYC, 18000, idle-low cycles before each packet (750 us at 24 MHz)
GS_BITS, 12, grayscale bits per channel
CH_PER_IC, 3, channels per IC (A, B, C)
GAPS_PER_FRAME, 2, gap symbols after every 36-bit frame

Ports:
pixel_clock  in  1  block clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a packet when idle
ic_count_m1  in  10  number of cascaded ICs minus 1 (0..1023); latched at start
gclk_sel  in  2  header GCLK field; latched at start
cmd  in  8  header command (8'h00 grayscale, 8'h55 soft reset); latched at start
s_data  in  GS_BITS  grayscale sample, channel A first
s_valid  in  1  sample valid
s_ready  out  1  sample accepted when s_valid & s_ready
busy  out  1  high from accepted start until packet end
done  out  1  one-cycle pulse on the last cycle of the packet
underrun  out  1  sticky; set when a frame had no complete buffered data; cleared at start
data_out  out  1  MBI6120 serial line

Behaviour:
- Reset:
  - state IDLE; data_out=0, busy=0, done=0, underrun=0, s_ready=0.
  - Prefetch buffer cleared.
  - Reset mid-packet aborts; data_out is 0 from the next edge.
- Symbol encoding, from the start of a symbol:
  - '0': high for TW_CYC, then low until BIT_CYC.
  - '1': high for BIT_CYC-TW_CYC, then low.
  - Gap: period 2*BIT_CYC, high for 2*BIT_CYC-TW_CYC.
  - All frames are sent MSB first.
- Header frame: {12'hFFF, 2'b00, gclk_sel, cmd, 2'b00, ic_count_m1}.
- IC frame: {chA, chB, chC}, each 12 bits.
- Every frame (header included) is followed by GAPS_PER_FRAME gap symbols.
- Frame duration: 40*BIT_CYC = 1920 cycles.
- States:
  - IDLE: start -> LATCH, busy=1, latch inputs. start while busy is ignored.
  - LATCH: data_out=0 for LATCH_CYC cycles -> HEADER.
  - HEADER: 36 symbols -> GAP.
  - GAP: GAPS_PER_FRAME gap symbols.
    - If ICs remain -> FRAME: load the shifter from the prefetch buffer; buffer marked empty.
    - Otherwise -> DONE.
  - FRAME: 36 symbols -> GAP.
  - DONE: done=1 for 1 cycle, busy=0 -> IDLE.
- Prefetch:
  - s_ready is high while busy, the buffer holds fewer than CH_PER_IC samples, and the samples already taken for the packet are fewer than (ic_count_m1+1)*CH_PER_IC.
  - Filling starts in LATCH.
- Underrun: if the buffer is incomplete when GAP->FRAME loads, all-zero frame data is sent and underrun is set.
  - Any partial samples are discarded.
  - Prefetch resumes for the next IC.
- IC counter: 11 bits; counts down from ic_count_m1+1 with no wrap.
- Total packet length: LATCH_CYC + (ic_count_m1+2)*1920 + 1 cycles.

Optional Feature:
- Macro MBI6120_DOUBLE_PIXEL_EN.
- When defined:
  - Adds input double_pixel (1 bit, latched at start).
  - When latched high, each buffered triple is transmitted to two consecutive ICs; only ceil((ic_count_m1+1)/2)*CH_PER_IC samples are consumed.
  - The buffer empties only after the second use.
  - The header count is unchanged.
- When undefined: port absent; each triple is sent once.

Decomposition:
- Package mbi6120_pkg:
  - State enum.
  - PREAMBLE=12'hFFF, FRAME_BITS=36.
  - CMD_GRAYSCALE=8'h00, CMD_SOFT_RESET=8'h55.
  - GCLK codes 2'b00..2'b11.
  - Symbol-type enum {SYM_0, SYM_1, SYM_GAP}.
- Sub-module mbi6120_symbol_gen:
  - Inputs: sym_type and sym_start strobe.
  - Drives data_out timing with its own cycle counter.
  - Returns sym_done on the last cycle of the symbol, so the next symbol starts back-to-back.

Test Plan:
1. BIT_CYC=48, TW_CYC=5, ic_count_m1=0, gclk_sel=01, cmd=00, samples 0xABC, 0x123, 0xFFF -> decoded bits header 0xFFF_1_00_000, then 0xABC123FFF. Highs are 5/43 cycles; gap highs are 91. done fires at cycle 18000+2*1920 after start.
2. s_valid held low for the whole packet, ic_count_m1=1 -> two all-zero IC frames, underrun=1 at done. The next start clears underrun.
3. ic_count_m1=1023 with an always-valid source -> exactly 3072 samples accepted. Header count field = 10'h3FF. No underrun.
4. start pulsed again mid-FRAME -> ignored, single done. rst asserted mid-FRAME -> data_out=0, busy=0 on the next edge; a subsequent start produces a full correct packet.
5. cmd=8'h55 soft reset, ic_count_m1=2 -> header field bits [19:12]=01010101, three frames sent.
6. With MBI6120_DOUBLE_PIXEL_EN, double_pixel=1, ic_count_m1=3 -> 6 samples consumed. Frames sent in order: T0, T0, T1, T1.
